// File: rtl/sfifo_param_if.sv
// sfifo_param_if: data-side bundle of the single-clock FIFO (producer/consumer signals)
interface sfifo_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) ();
    logic                     clr_i;
    logic                     we_i;
    logic [DATA_WIDTH-1:0]    data_w;
    logic                     re_i;
    logic [DATA_WIDTH-1:0]    data_r;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output clr_i, we_i, data_w, re_i,
        input  data_r, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr_i, we_i, data_w, re_i,
        output data_r, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sfifo_param.sv
// sfifo_param: single-clock FIFO with count, almost flags, sticky errors, flush; SFIFO_FWFT_EN selects fall-through read
module sfifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          arst,
    sfifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DL  = DEPTH[AW:0];
    localparam logic [AW:0] AFL = AF_LEVEL[AW:0];
    localparam logic [AW:0] AEL = AE_LEVEL[AW:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr, r_rptr, r_count;
    logic                  r_full, r_empty, r_af, r_ae, r_ov, r_un;
    logic                  w_wr_ok, w_rd_ok;
    logic [AW:0]           w_cnt_next;

    assign w_wr_ok    = bus.we_i & (~r_full | bus.re_i);
    assign w_rd_ok    = bus.re_i & ~r_empty;
    assign w_cnt_next = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);

    // pointers, occupancy, registered flags and sticky errors
    always_ff @(posedge clk) begin
        if (arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ov    <= 1'b0;
            r_un    <= 1'b0;
        end else if (bus.clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            r_wptr  <= r_wptr + (AW+1)'(w_wr_ok);
            r_rptr  <= r_rptr + (AW+1)'(w_rd_ok);
            r_count <= w_cnt_next;
            r_full  <= w_cnt_next == DL;
            r_empty <= w_cnt_next == '0;
            r_af    <= w_cnt_next >= AFL;
            r_ae    <= w_cnt_next <= AEL;
            r_ov    <= r_ov | (bus.we_i & ~w_wr_ok);
            r_un    <= r_un | (bus.re_i & ~w_rd_ok);
        end
    end

    // storage write; array deliberately has no reset
    always_ff @(posedge clk) begin
        if (!arst && !bus.clr_i && w_wr_ok) r_mem[r_wptr[AW-1:0]] <= bus.data_w;
    end

`ifdef SFIFO_FWFT_EN
    assign bus.data_r = r_mem[r_rptr[AW-1:0]];
`else
    logic [DATA_WIDTH-1:0] r_data_r;

    // registered read: head word captured on the accepting edge
    always_ff @(posedge clk) begin
        if (arst) r_data_r <= '0;
        else if (!bus.clr_i && w_rd_ok) r_data_r <= r_mem[r_rptr[AW-1:0]];
    end

    assign bus.data_r = r_data_r;
`endif

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ov;
    assign bus.underflow    = r_un;
endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: queue-model scoreboard bench for sfifo_param (DEPTH=16, DATA_WIDTH=32)
module tb_sfifo_param;
    logic clk = 1'b0;
    logic arst;
    int total = 0;
    int bad = 0;

    logic [31:0] q[$];
    logic        m_ov, m_un, m_rd;
    logic [31:0] m_dr;

    sfifo_param_if #(.DATA_WIDTH(32), .DEPTH(16)) bus ();
    sfifo_param #(.DATA_WIDTH(32), .DEPTH(16)) dut (.clk(clk), .arst(arst), .bus(bus));

    always #5 clk = ~clk;

    // drive one cycle, advance the queue model from the spec rules, sample 1 time unit after the edge
    task automatic step(input logic a, input logic c, input logic w, input logic r, input logic [31:0] d);
        logic wr, rd;
        arst = a; bus.clr_i = c; bus.we_i = w; bus.re_i = r; bus.data_w = d;
        @(posedge clk);
        #1;
        m_rd = 1'b0;
        if (a) begin
            q.delete(); m_ov = 0; m_un = 0; m_dr = 0;
        end else if (c) begin
            q.delete();
        end else begin
            wr = w && (q.size() < 16 || r);
            rd = r && q.size() > 0;
            if (w && !wr) m_ov = 1;
            if (r && !rd) m_un = 1;
            if (rd) begin m_dr = q.pop_front(); m_rd = 1; end
            if (wr) q.push_back(d);
        end
        arst = 0; bus.clr_i = 0; bus.we_i = 0; bus.re_i = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 1, 1, 32'hFFFF_FFFF);
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow} !== 6'b101000)
            begin bad++; $display("FAIL reset_flags got=%b exp=101000", {bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow}); end
`ifndef SFIFO_FWFT_EN
        total++; if (bus.data_r !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.data_r); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 32'h100 + i);
            total++; if (bus.count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, i + 1); end
            total++; if (bus.almost_full !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, bus.almost_full, i + 1 >= 14); end
            total++; if (bus.full !== (i == 15)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.full, i == 15); end
            total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf i=%0d got=%b exp=0", i, bus.overflow); end
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 1, 0, 32'hDEAD_BEEF);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        step(0, 0, 0, 0, 0);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
`ifdef SFIFO_FWFT_EN
            total++; if (bus.data_r !== 32'h100 + i) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.data_r, 32'h100 + i); end
            step(0, 0, 0, 1, 0);
`else
            step(0, 0, 0, 1, 0);
            total++; if (bus.data_r !== 32'h100 + i) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.data_r, 32'h100 + i); end
`endif
            total++; if (bus.count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, bus.count, 15 - i); end
            total++; if (bus.almost_empty !== (15 - i <= 2)) begin bad++; $display("FAIL drain_ae i=%0d got=%b exp=%b", i, bus.almost_empty, 15 - i <= 2); end
            total++; if (bus.empty !== (i == 15)) begin bad++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, bus.empty, i == 15); end
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 1, 0);
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", bus.underflow); end
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
        step(0, 0, 1, 1, 32'h55);
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL unf_wr_count got=%0d exp=1", bus.count); end
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", bus.underflow); end
`ifdef SFIFO_FWFT_EN
        total++; if (bus.data_r !== 32'h55) begin bad++; $display("FAIL unf_data got=%h exp=55", bus.data_r); end
        step(0, 0, 0, 1, 0);
`else
        step(0, 0, 0, 1, 0);
        total++; if (bus.data_r !== 32'h55) begin bad++; $display("FAIL unf_data got=%h exp=55", bus.data_r); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] head;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) begin
            head = q.size() > 0 ? q[0] : 32'h0;
`ifdef SFIFO_FWFT_EN
            if (q.size() > 0) begin
                total++; if (bus.data_r !== head) begin bad++; $display("FAIL rnd_head i=%0d got=%h exp=%h", i, bus.data_r, head); end
            end
`endif
            step(0, 0, ($urandom % 4) != 0, ($urandom % 2) != 0, $urandom);
            total++; if (bus.count !== 5'(q.size()) || bus.count > 5'd16) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, bus.count, q.size()); end
            total++; if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !== {q.size() == 16, q.size() == 0, q.size() >= 14, q.size() <= 2})
                begin bad++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, {q.size() == 16, q.size() == 0, q.size() >= 14, q.size() <= 2}); end
            total++; if ({bus.overflow, bus.underflow} !== {m_ov, m_un}) begin bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, {bus.overflow, bus.underflow}, {m_ov, m_un}); end
`ifndef SFIFO_FWFT_EN
            if (m_rd) begin
                total++; if (bus.data_r !== m_dr) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, bus.data_r, m_dr); end
            end
`endif
        end
    endtask

    task automatic test_full_rw();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 32'hA00 + i);
        step(0, 0, 1, 1, 32'hBEEF);
        total++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin bad++; $display("FAIL fullrw_count got=%0d/%b exp=16/1", bus.count, bus.full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", bus.overflow); end
`ifndef SFIFO_FWFT_EN
        total++; if (bus.data_r !== 32'hA00) begin bad++; $display("FAIL fullrw_data got=%h exp=a00", bus.data_r); end
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef SFIFO_FWFT_EN
            total++; if (bus.data_r !== q[0]) begin bad++; $display("FAIL fullrw_drain i=%0d got=%h exp=%h", i, bus.data_r, q[0]); end
            step(0, 0, 0, 1, 0);
`else
            step(0, 0, 0, 1, 0);
            total++; if (bus.data_r !== m_dr) begin bad++; $display("FAIL fullrw_drain i=%0d got=%h exp=%h", i, bus.data_r, m_dr); end
`endif
        end
        total++; if (m_dr !== 32'hBEEF && bus.empty !== 1'b1) begin bad++; $display("FAIL fullrw_last got=%b exp=1", bus.empty); end
    endtask

    task automatic test_clear();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 32'hC00 + i);
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 32'h1234);
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL clr_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
        total++; if ({bus.full, bus.almost_full, bus.almost_empty} !== 3'b001) begin bad++; $display("FAIL clr_flags got=%b exp=001", {bus.full, bus.almost_full, bus.almost_empty}); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b01) begin bad++; $display("FAIL clr_err got=%b exp=01", {bus.overflow, bus.underflow}); end
`ifndef SFIFO_FWFT_EN
        total++; if (bus.data_r !== 32'hC00) begin bad++; $display("FAIL clr_data got=%h exp=c00", bus.data_r); end
`endif
        step(0, 0, 1, 0, 32'h77);
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL clr_after got=%0d exp=1", bus.count); end
        step(1, 0, 1, 0, 32'h88);
        total++; if ({bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow} !== {5'd0, 6'b101000})
            begin bad++; $display("FAIL clr_reset got=%b exp=%b", {bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow}, {5'd0, 6'b101000}); end
`ifndef SFIFO_FWFT_EN
        total++; if (bus.data_r !== 32'h0) begin bad++; $display("FAIL clr_reset_data got=%h exp=0", bus.data_r); end
`endif
    endtask

    initial begin
        arst = 1; bus.clr_i = 0; bus.we_i = 0; bus.re_i = 0; bus.data_w = 0;
        m_ov = 0; m_un = 0; m_dr = 0; m_rd = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_random();
        test_full_rw();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
